// File: rtl/uart_transmitter.sv
// uart_transmitter: 8E1/8O1 serial transmitter.
// Frame: start(0), 8 data bits LSB first, parity, stop(1), each one bit period long.
// One bit period is OVERSAMPLE baud ticks, and one baud tick is a divider
// chosen by baud_select (50 MHz clock). baud_select is captured with each
// accepted write, so a change during a frame only affects the next frame.
module uart_transmitter #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  state_t      r_state;
  logic [7:0]  r_data;
  logic [2:0]  r_sel;
  logic        r_parity;
  logic [13:0] r_baud_cnt;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_idx;

  logic [13:0] w_div_last;
  logic        w_tick;
  logic        w_bit_end;

  // Terminal count of the baud divider for the baud code captured at acceptance.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_div_last = 14'd26;
    case (r_sel)
      3'b000:  w_div_last = 14'd10416;
      3'b001:  w_div_last = 14'd2603;
      3'b010:  w_div_last = 14'd650;
      3'b011:  w_div_last = 14'd325;
      3'b100:  w_div_last = 14'd162;
      3'b101:  w_div_last = 14'd80;
      3'b110:  w_div_last = 14'd53;
      default: w_div_last = 14'd26;
    endcase
  end

  assign w_tick    = (r_baud_cnt == w_div_last);
  assign w_bit_end = w_tick && (r_tick_cnt == TICK_LAST);

  // Frame sequencer: baud/tick counters, state, and the registered line outputs.
  // NOTE: every sequential assignment is non-blocking so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: r_data, r_sel and r_parity are not reset; they are always
      // reloaded by an accepted write before anything reads them.
      r_state    <= S_IDLE;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
      r_baud_cnt <= '0;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
    end else begin
      if (r_state != S_IDLE) begin
        if (w_tick) begin
          r_baud_cnt <= '0;
          r_tick_cnt <= w_bit_end ? 4'd0 : r_tick_cnt + 4'd1;
        end else begin
          r_baud_cnt <= r_baud_cnt + 14'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
          if (Tx_WR && Tx_EN) begin
            r_data     <= Tx_DATA;
            r_sel      <= baud_select;
            r_parity   <= (^Tx_DATA) ^ PARITY_ODD;
            r_baud_cnt <= '0;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            TxD        <= 1'b0;
            Tx_BUSY    <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_bit_idx <= '0;
            TxD       <= r_data[0];
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == 3'd7) begin
              TxD     <= r_parity;
              r_state <= S_PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              TxD       <= r_data[r_bit_idx + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            TxD     <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          TxD     <= 1'b1;
          Tx_BUSY <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
